// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave in front of a 2**ADDR_W x 32-bit SRAM with optional wait states.
// Define AHB_SRAM_ERROR_EN to add two-cycle ERROR responses for illegal transfers.
module ahb_sram_ctrl #(
   parameter int ADDR_W      = 15,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

`ifdef AHB_SRAM_ERROR_EN
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_DATA = 3'd2, ST_ERR1 = 3'd3, ST_ERR2 = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_DATA = 3'd2
   } state_t;
`endif

   state_t              state_r;
   logic [3:0]          cnt_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [3:0]          lane_r;
   logic                write_r;
   logic [31:0]         hrdata_r;
   logic                hreadyout_r;
   logic                hresp_r;
   logic [31:0]         mem_r [0:(1<<ADDR_W)-1];

   logic                accept_s;
   logic [ADDR_W-1:0]   haddr_idx_s;
   logic [ADDR_W-1:0]   rd_idx_s;
   logic                fwd_s;
   logic [31:0]         rd_word_s;
   logic                commit_s;
   logic                unused_s;

   function automatic logic [3:0] lane_decode(input logic [2:0] size, input logic [1:0] lsb);
      logic [3:0] be;
      case (size)
         3'd0:    be = 4'b0001 << lsb;
         3'd1:    be = lsb[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old_d, input logic [31:0] new_d,
                                              input logic [3:0] be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
      end
      return res;
   endfunction

   assign accept_s    = HSEL & HTRANS[1] & HREADY;
   assign haddr_idx_s = HADDR[ADDR_W+1:2];
   assign rd_idx_s    = (state_r == ST_WAIT) ? addr_r : haddr_idx_s;
   // A read launched in a write's DATA cycle sees the bytes that write is committing now.
   assign fwd_s       = (state_r == ST_DATA) & write_r & (addr_r == rd_idx_s);
   assign rd_word_s   = fwd_s ? byte_merge(mem_r[rd_idx_s], HWDATA, lane_r) : mem_r[rd_idx_s];
   assign commit_s    = (state_r == ST_DATA) & write_r & ~HRESET;
   assign unused_s    = ^{HTRANS[0], HADDR[31:ADDR_W+2]};

`ifdef AHB_SRAM_ERROR_EN
   logic err_s;
   assign err_s = ((HADDR >> (ADDR_W + 2)) != 32'd0) | (HSIZE > 3'd2)
                | ((HSIZE == 3'd1) & HADDR[0])
                | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
`endif

   assign HRDATA    = hrdata_r;
   assign HREADYOUT = hreadyout_r;
   assign HRESP     = hresp_r;

   // Transfer FSM: address capture, wait counting and registered bus outputs.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         addr_r      <= '0;
         lane_r      <= 4'd0;
         write_r     <= 1'b0;
         hrdata_r    <= 32'd0;
         hreadyout_r <= 1'b1;
         hresp_r     <= 1'b0;
      end else begin
         hrdata_r <= 32'd0;
         case (state_r)
            ST_WAIT: begin
               if (cnt_r == 4'd1) begin
                  state_r     <= ST_DATA;
                  cnt_r       <= 4'd0;
                  hreadyout_r <= 1'b1;
                  if (!write_r) begin
                     hrdata_r <= rd_word_s;
                  end
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
`ifdef AHB_SRAM_ERROR_EN
            ST_ERR1: begin
               state_r     <= ST_ERR2;
               hreadyout_r <= 1'b1;
               hresp_r     <= 1'b1;
            end
            ST_IDLE, ST_DATA, ST_ERR2: begin
`else
            ST_IDLE, ST_DATA: begin
`endif
               if (accept_s) begin
                  addr_r  <= haddr_idx_s;
                  lane_r  <= lane_decode(HSIZE, HADDR[1:0]);
                  write_r <= HWRITE;
`ifdef AHB_SRAM_ERROR_EN
                  if (err_s) begin
                     state_r     <= ST_ERR1;
                     write_r     <= 1'b0;
                     hreadyout_r <= 1'b0;
                     hresp_r     <= 1'b1;
                  end else
`endif
                  if (WAIT_STATES > 0) begin
                     state_r     <= ST_WAIT;
                     cnt_r       <= 4'(WAIT_STATES);
                     hreadyout_r <= 1'b0;
                     hresp_r     <= 1'b0;
                  end else begin
                     state_r     <= ST_DATA;
                     hreadyout_r <= 1'b1;
                     hresp_r     <= 1'b0;
                     if (!HWRITE) begin
                        hrdata_r <= rd_word_s;
                     end
                  end
               end else begin
                  state_r     <= ST_IDLE;
                  hreadyout_r <= 1'b1;
                  hresp_r     <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cnt_r       <= 4'd0;
               write_r     <= 1'b0;
               hreadyout_r <= 1'b1;
               hresp_r     <= 1'b0;
            end
         endcase
      end
   end

   // SRAM array: byte-lane write on the edge that closes a write DATA cycle.
   always_ff @(posedge HCLK) begin
      if (commit_s) begin
         mem_r[addr_r] <= byte_merge(mem_r[addr_r], HWDATA, lane_r);
      end
   end

endmodule
